rom_loader: RTL and testbench

Writer-side companion to the synchronous 8K×8 program ROM. Accepts a byte stream from a host download path (valid/ready), writes it sequentially into a RAM-backed program store through an active-low write strobe, and holds the CPU in reset until a full image has landed. Sits between the host/download interface and the program memory's write port. The CPU core sees a normal ROM once `done` is asserted.

---
 rtl/rom_loader.sv | 110 +++++++++++
 tb/tb_rom_loader.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/rom_loader.sv
// rom_loader: streams host bytes into program memory and holds the CPU in reset until the image lands.
// Optional trailer checksum check is enabled by defining ROM_LOADER_CHECKSUM_EN.
module rom_loader #(
    parameter int AW = 13,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    output logic          s_ready,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_d,
    output logic          mem_we_n,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          cpu_reset_n
);
    typedef enum logic [2:0] {IDLE, LOAD, CHECK, DONE, ERROR} state_t;
    state_t state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d, mem_a_q, mem_a_d;
    logic [DW-1:0] mem_d_q, mem_d_d;
    logic we_n_q, we_n_d, busy_q, busy_d, done_q, done_d, xfer;
`ifdef ROM_LOADER_CHECKSUM_EN
    logic [DW-1:0] sum_q, sum_d;
    logic err_q, err_d;
`endif
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        mem_a_d = mem_a_q;
        mem_d_d = mem_d_q;
        we_n_d = 1'b1;
        xfer = s_valid && busy_q;
`ifdef ROM_LOADER_CHECKSUM_EN
        sum_d = sum_q;
`endif
        case (state_q)
            LOAD: if (xfer) begin
                mem_a_d = cnt_q;
                mem_d_d = s_data;
                we_n_d = 1'b0;
                cnt_d = cnt_q + AW'(1);
`ifdef ROM_LOADER_CHECKSUM_EN
                sum_d = sum_q + s_data;
                if (&cnt_q) state_d = CHECK;
`else
                if (&cnt_q) state_d = DONE;
`endif
            end
`ifdef ROM_LOADER_CHECKSUM_EN
            // trailer is consumed but never written to memory
            CHECK: if (xfer) state_d = (DW'(sum_q + s_data) == '0) ? DONE : ERROR;
`endif
            default: if (start) begin
                state_d = LOAD;
                cnt_d = '0;
`ifdef ROM_LOADER_CHECKSUM_EN
                sum_d = '0;
`endif
            end
        endcase
        busy_d = state_d inside {LOAD, CHECK};
        done_d = state_d == DONE;
`ifdef ROM_LOADER_CHECKSUM_EN
        err_d = state_d == ERROR;
`endif
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q <= '0;
            mem_a_q <= '0;
            mem_d_q <= '0;
            we_n_q <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
            sum_q <= '0;
            err_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            mem_a_q <= mem_a_d;
            mem_d_q <= mem_d_d;
            we_n_q <= we_n_d;
            busy_q <= busy_d;
            done_q <= done_d;
`ifdef ROM_LOADER_CHECKSUM_EN
            sum_q <= sum_d;
            err_q <= err_d;
`endif
        end
    end
    assign s_ready = busy_q;
    assign busy = busy_q;
    assign mem_a = mem_a_q;
    assign mem_d = mem_d_q;
    assign mem_we_n = we_n_q;
    assign done = done_q;
    assign cpu_reset_n = done_q;
`ifdef ROM_LOADER_CHECKSUM_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: random/directed loads checked every cycle against a phase-level model of the loader.
module tb_rom_loader;
    localparam int AW = 13, DW = 8, N = 1 << AW;
`ifdef ROM_LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif
    logic clk = 1'b0, reset_n = 1'b1, start = 1'b0, s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic s_ready, mem_we_n, busy, done, err, cpu_reset_n;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_d;
    rom_loader #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .mem_a(mem_a), .mem_d(mem_d), .mem_we_n(mem_we_n),
        .busy(busy), .done(done), .err(err), .cpu_reset_n(cpu_reset_n)
    );
    always #5 clk = ~clk;
    int total = 0, bad = 0;
    typedef enum {M_IDLE, M_LOAD, M_CHECK, M_DONE, M_ERR} ph_t;
    ph_t ph = M_IDLE;
    int n = 0, hs = 0, strobes = 0, last_a = 0, last_d = 0, sum = 0;
    bit we_exp = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // model: phase per cycle, bytes accepted so far, expected write from the previous cycle
    always @(negedge clk) begin
        if (!reset_n) begin
            ph = M_IDLE;
            we_exp = 1'b0;
            last_a = 0;
            last_d = 0;
        end
        chk("s_ready", s_ready, ph == M_LOAD || ph == M_CHECK);
        chk("busy", busy, ph == M_LOAD || ph == M_CHECK);
        chk("done", done, ph == M_DONE);
        chk("cpu_reset_n", cpu_reset_n, ph == M_DONE);
        chk("err", err, ph == M_ERR);
        chk("mem_we_n", mem_we_n, !we_exp);
        chk("mem_a", mem_a, last_a);
        chk("mem_d", mem_d, last_d);
        if (mem_we_n === 1'b0) strobes++;
        we_exp = 1'b0;
        if (reset_n) begin
            if (ph inside {M_IDLE, M_DONE, M_ERR}) begin
                if (start) begin
                    ph = M_LOAD;
                    n = 0;
                    sum = 0;
                end
            end else if (s_valid && ph == M_LOAD) begin
                we_exp = 1'b1;
                last_a = n % N;
                last_d = s_data;
                sum = (sum + s_data) % 256;
                n++;
                hs++;
                if (n == N) ph = CK ? M_CHECK : M_DONE;
            end else if (s_valid) begin
                ph = ((sum + s_data) % 256 == 0) ? M_DONE : M_ERR;
            end
        end
    end

    // mode 0: data = byte index, mode 1: random valid/data, mode 2: constant byte; trailer[8] = auto-correct trailer
    task automatic load(input int mode, input logic [7:0] fixed, input logic [8:0] trailer, input int restart_at);
        int cycles;
        @(posedge clk); #1 start = 1'b1; hs = 0; strobes = 0;
        @(posedge clk); #1 start = 1'b0;
        cycles = 0;
        while (!(ph == M_DONE || ph == M_ERR) && cycles < 4 * N) begin
            s_valid = (mode == 1) ? 1'($urandom_range(1, 0)) : 1'b1;
            if (ph == M_CHECK) s_data = trailer[8] ? 8'(256 - sum) : trailer[7:0];
            else s_data = (mode == 0) ? 8'(n) : (mode == 1) ? 8'($urandom) : fixed;
            start = (ph == M_LOAD && n == restart_at);
            @(posedge clk); #1;
            cycles++;
        end
        s_valid = 1'b0;
        start = 1'b0;
        chk("load_timeout", cycles < 4 * N, 1'b1);
        @(negedge clk); #1;
        chk("strobe_count", strobes, hs);
        chk("image_len", hs, N);
    endtask

    initial begin
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        strobes = 0;
        repeat (20) begin
            s_valid = 1'($urandom_range(1, 0));
            s_data = 8'($urandom);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        chk("idle_strobes", strobes, 0);
        load(0, 8'h00, 9'h100, 50);
        chk("stream_done", done, 1'b1);
        load(1, 8'h00, 9'h100, -1);
        chk("gap_final_mem_a", mem_a, N - 1);
        chk("gap_done", done, 1'b1);
`ifdef ROM_LOADER_CHECKSUM_EN
        load(2, 8'h01, 9'h000, -1);
        chk("ck_pass_done", done, 1'b1);
        load(2, 8'h01, 9'h005, -1);
        chk("ck_fail_err", err, 1'b1);
        chk("ck_fail_cpu_reset_n", cpu_reset_n, 1'b0);
`endif
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 400 && n < 100; i++) begin
            s_valid = 1'b1;
            s_data = 8'($urandom);
            @(posedge clk); #1;
        end
        chk("abort_bytes", n, 100);
        chk("abort_pending_strobe", mem_we_n, 1'b0);
        reset_n = 1'b0;
        s_valid = 1'b0;
        #1;
        chk("abort_we_n", mem_we_n, 1'b1);
        chk("abort_busy", busy, 1'b0);
        chk("abort_mem_a", mem_a, 0);
        chk("abort_done", done, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        load(0, 8'h00, 9'h100, -1);
        chk("after_abort_done", done, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
